fib_key_entry_ctrl: RTL and testbench

- Sequencer between the PS/2 key-code FIFO (kb_code), the UART echo path and the Fibonacci unit (fib).
- Pops make-codes one at a time and assembles up to two decimal digits into a binary index.
- On Enter, range-checks the index, then issues a single start pulse to fib and waits for its completion.
- Replaces ad-hoc two-code capture with a handshaked, validated entry path.

---
 rtl/fib_key_entry_ctrl_if.sv | 23 ++
 rtl/fib_key_entry_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_fib_key_entry_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fib_key_entry_ctrl_if.sv
// Handshake bundle between the key-entry sequencer, the PS/2 key FIFO,
// the UART echo path and the Fibonacci unit.
interface fib_key_entry_ctrl_if;
    logic       kb_buf_empty;
    logic [7:0] key_code;
    logic       rd_key_code;
    logic       tx_full;
    logic       echo_wr;
    logic [7:0] echo_data;
    logic       fib_busy;
    logic       fib_done;
    logic       fib_start;

    modport master (
        input  kb_buf_empty, key_code, tx_full, fib_busy, fib_done,
        output rd_key_code, echo_wr, echo_data, fib_start
    );

    modport slave (
        output kb_buf_empty, key_code, tx_full, fib_busy, fib_done,
        input  rd_key_code, echo_wr, echo_data, fib_start
    );
endinterface

// File: rtl/fib_key_entry_ctrl.sv
// Key-entry sequencer: pops PS/2 make codes, builds a 0..99 index, echoes it and
// starts the Fibonacci unit. Optional idle timeout via macro ENTRY_TIMEOUT_EN.
module fib_key_entry_ctrl #(
    parameter int MAX_INDEX      = 24,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic                 clk,
    input  logic                 reset,
    fib_key_entry_ctrl_if.master bus,
    output logic [7:0]           index,
    output logic [6:0]           entry_val,
    output logic [1:0]           digit_cnt,
    output logic                 entry_err
);

    typedef enum logic [2:0] {
        IDLE, DECODE, ECHO, COMMIT, WAIT_DONE
    } state_t;

    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_BKSP  = 8'h66;
    localparam logic [7:0] CH_ZERO   = 8'h30;
    localparam logic [7:0] CH_BANG   = 8'h21;
    localparam logic [7:0] CH_DASH   = 8'h2D;
    localparam logic [7:0] CH_CR     = 8'h0D;

    state_t     state_q, state_d;
    logic [7:0] key_q, key_d;
    logic [6:0] entry_val_q, entry_val_d;
    logic [1:0] digit_cnt_q, digit_cnt_d;
    logic       entry_err_q, entry_err_d;
    logic [7:0] index_q, index_d;
    logic [7:0] echo_data_q, echo_data_d;
    logic       commit_q, commit_d;
    logic       gap_q, gap_d;

    logic       rd_key_code, echo_wr, fib_start;
    logic       is_digit;
    logic [3:0] digit;
    logic [6:0] accum;

`ifdef ENTRY_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        is_digit = 1'b1;
        digit    = 4'd0;
        case (key_q)
            8'h45: digit = 4'd0;
            8'h16: digit = 4'd1;
            8'h1E: digit = 4'd2;
            8'h26: digit = 4'd3;
            8'h25: digit = 4'd4;
            8'h2E: digit = 4'd5;
            8'h36: digit = 4'd6;
            8'h3D: digit = 4'd7;
            8'h3E: digit = 4'd8;
            8'h46: digit = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end

    // Bounded by 9*10+9 = 99, so 7 bits never overflow.
    assign accum = entry_val_q * 7'd10 + {3'b000, digit};

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        entry_val_d = entry_val_q;
        digit_cnt_d = digit_cnt_q;
        entry_err_d = entry_err_q;
        index_d     = index_q;
        echo_data_d = echo_data_q;
        commit_d    = commit_q;
        gap_d       = 1'b0;
        rd_key_code = 1'b0;
        echo_wr     = 1'b0;
        fib_start   = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
        tmo_cnt_d   = '0;
`endif

        case (state_q)
            IDLE: begin
                // gap_q spaces pops after an ignored key so the FIFO sees at most one pop per 3 cycles.
                if (!bus.kb_buf_empty && !gap_q) begin
                    rd_key_code = 1'b1;
                    key_d       = bus.key_code;
                    state_d     = DECODE;
                end
`ifdef ENTRY_TIMEOUT_EN
                else if (digit_cnt_q != 2'd0) begin
                    if (tmo_cnt_q == TMO_LAST) begin
                        entry_val_d = '0;
                        digit_cnt_d = '0;
                        entry_err_d = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
`endif
            end

            DECODE: begin
                commit_d = 1'b0;
                state_d  = ECHO;
                if (is_digit) begin
                    if (digit_cnt_q < 2'd2) begin
                        entry_val_d = accum;
                        digit_cnt_d = digit_cnt_q + 2'd1;
                        entry_err_d = 1'b0;
                        echo_data_d = CH_ZERO + {4'h0, digit};
                    end else begin
                        entry_err_d = 1'b1;
                        echo_data_d = CH_BANG;
                    end
                end else if (key_q == KEY_BKSP) begin
                    entry_val_d = '0;
                    digit_cnt_d = '0;
                    entry_err_d = 1'b0;
                    echo_data_d = CH_DASH;
                end else if (key_q == KEY_ENTER) begin
                    if (digit_cnt_q == 2'd0) begin
                        state_d = IDLE;
                        gap_d   = 1'b1;
                    end else if (entry_val_q > 7'(MAX_INDEX)) begin
                        entry_err_d = 1'b1;
                        entry_val_d = '0;
                        digit_cnt_d = '0;
                        echo_data_d = CH_BANG;
                    end else begin
                        index_d     = {1'b0, entry_val_q};
                        echo_data_d = CH_CR;
                        commit_d    = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    gap_d   = 1'b1;
                end
            end

            ECHO: begin
                if (!bus.tx_full) begin
                    echo_wr = 1'b1;
                    state_d = commit_q ? COMMIT : IDLE;
                end
            end

            COMMIT: begin
                if (!bus.fib_busy) begin
                    fib_start   = 1'b1;
                    entry_val_d = '0;
                    digit_cnt_d = '0;
                    commit_d    = 1'b0;
                    state_d     = WAIT_DONE;
                end
            end

            WAIT_DONE: begin
                if (bus.fib_done) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            key_q       <= '0;
            entry_val_q <= '0;
            digit_cnt_q <= '0;
            entry_err_q <= 1'b0;
            index_q     <= '0;
            echo_data_q <= '0;
            commit_q    <= 1'b0;
            gap_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            entry_val_q <= entry_val_d;
            digit_cnt_q <= digit_cnt_d;
            entry_err_q <= entry_err_d;
            index_q     <= index_d;
            echo_data_q <= echo_data_d;
            commit_q    <= commit_d;
            gap_q       <= gap_d;
        end
    end

`ifdef ENTRY_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tmo_cnt_q <= '0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end
`endif

    assign bus.rd_key_code = rd_key_code;
    assign bus.echo_wr     = echo_wr;
    assign bus.echo_data   = echo_data_q;
    assign bus.fib_start   = fib_start;

    assign index     = index_q;
    assign entry_val = entry_val_q;
    assign digit_cnt = digit_cnt_q;
    assign entry_err = entry_err_q;

endmodule

// File: tb/tb_fib_key_entry_ctrl.sv
// Directed bench for fib_key_entry_ctrl: FIFO/UART/fib environment model with
// hand-computed expected echoes, indices and strobe counts.
module tb_fib_key_entry_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] index;
    logic [6:0] entry_val;
    logic [1:0] digit_cnt;
    logic       entry_err;

    fib_key_entry_ctrl_if ifc ();

    fib_key_entry_ctrl #(.MAX_INDEX(24), .TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (ifc.master),
        .index     (index),
        .entry_val (entry_val),
        .digit_cnt (digit_cnt),
        .entry_err (entry_err)
    );

    always #5 clk = ~clk;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   rd_cnt = 0;
    int   echo_cnt = 0;
    int   start_cnt = 0;
    int   viol_cnt = 0;
    logic pop_req = 1'b0;
    logic [7:0] kq[$];
    int   echo_q[$];

    task automatic check(input string tag, input int got, input int exp);
        total_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic expect_echo(input string tag, input int exp);
        int got;
        got = -1;
        if (echo_q.size() > 0) got = echo_q.pop_front();
        check(tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Key FIFO model: first-word fall-through, pop applied just after the edge.
    always begin
        @(posedge clk);
        #2;
        if (pop_req && kq.size() > 0) void'(kq.pop_front());
        ifc.kb_buf_empty = (kq.size() == 0);
        ifc.key_code     = (kq.size() > 0) ? kq[0] : 8'h00;
    end

    // Transaction monitor sampled mid-cycle.
    always @(negedge clk) begin
        pop_req = ifc.rd_key_code;
        if (ifc.rd_key_code) rd_cnt++;
        if (ifc.echo_wr) begin
            echo_cnt++;
            echo_q.push_back(int'(ifc.echo_data));
            $display("%0t echo 0x%02h", $time, ifc.echo_data);
        end
        if (ifc.fib_start) begin
            start_cnt++;
            $display("%0t fib_start index=%0d", $time, index);
        end
        if (int'(ifc.rd_key_code) + int'(ifc.echo_wr) + int'(ifc.fib_start) > 1) viol_cnt++;
        if (ifc.echo_wr && ifc.tx_full) viol_cnt++;
    end

    int rd0, ec0, st0;

    initial begin
        ifc.kb_buf_empty = 1'b1;
        ifc.key_code     = 8'h00;
        ifc.tx_full      = 1'b0;
        ifc.fib_busy     = 1'b0;
        ifc.fib_done     = 1'b0;
        tick(3);
        check("rst_rd", int'(ifc.rd_key_code), 0);
        check("rst_echo_wr", int'(ifc.echo_wr), 0);
        check("rst_start", int'(ifc.fib_start), 0);
        check("rst_index", int'(index), 0);
        check("rst_val", int'(entry_val), 0);
        check("rst_cnt", int'(digit_cnt), 0);
        check("rst_err", int'(entry_err), 0);
        check("rst_echo_data", int'(ifc.echo_data), 0);
        reset = 1'b1;
        tick(2);

        // "18" + Enter commits index 18
        kq.push_back(8'h16); kq.push_back(8'h3E); kq.push_back(8'h5A);
        tick(30);
        expect_echo("t1_e0", 8'h31);
        expect_echo("t1_e1", 8'h38);
        expect_echo("t1_e2", 8'h0D);
        check("t1_index", int'(index), 18);
        check("t1_starts", start_cnt, 1);
        check("t1_val", int'(entry_val), 0);
        check("t1_cnt", int'(digit_cnt), 0);
        // key arriving while waiting for fib_done must stay queued
        rd0 = rd_cnt;
        kq.push_back(8'h16);
        tick(12);
        check("t1_wait_nopop", rd_cnt - rd0, 0);
        check("t1_wait_fifo", kq.size(), 1);
        ifc.fib_done = 1'b1;
        tick(1);
        ifc.fib_done = 1'b0;
        tick(10);
        check("t1_after_pop", rd_cnt - rd0, 1);
        expect_echo("t1_e3", 8'h31);
        check("t1_cnt1", int'(digit_cnt), 1);
        kq.push_back(8'h66);
        tick(8);
        expect_echo("t1_bs", 8'h2D);
        check("t1_bs_cnt", int'(digit_cnt), 0);

        // "26" exceeds MAX_INDEX
        st0 = start_cnt;
        kq.push_back(8'h1E); kq.push_back(8'h36); kq.push_back(8'h5A);
        tick(30);
        expect_echo("t2_e0", 8'h32);
        expect_echo("t2_e1", 8'h36);
        expect_echo("t2_e2", 8'h21);
        check("t2_err", int'(entry_err), 1);
        check("t2_nostart", start_cnt - st0, 0);
        check("t2_val", int'(entry_val), 0);
        check("t2_cnt", int'(digit_cnt), 0);
        check("t2_index", int'(index), 18);

        // third digit rejected, then Backspace
        kq.push_back(8'h25); kq.push_back(8'h45); kq.push_back(8'h16);
        tick(30);
        expect_echo("t3_e0", 8'h34);
        expect_echo("t3_e1", 8'h30);
        expect_echo("t3_e2", 8'h21);
        check("t3_err", int'(entry_err), 1);
        check("t3_val", int'(entry_val), 40);
        check("t3_cnt", int'(digit_cnt), 2);
        kq.push_back(8'h66);
        tick(8);
        expect_echo("t3_bs", 8'h2D);
        check("t3_bs_val", int'(entry_val), 0);
        check("t3_bs_err", int'(entry_err), 0);

        // unknown code and empty Enter are silent
        rd0 = rd_cnt; ec0 = echo_cnt; st0 = start_cnt;
        kq.push_back(8'h1C); kq.push_back(8'h5A);
        tick(12);
        check("ign_pops", rd_cnt - rd0, 2);
        check("ign_echo", echo_cnt - ec0, 0);
        check("ign_start", start_cnt - st0, 0);

        // UART back-pressure
        ifc.tx_full = 1'b1;
        rd0 = rd_cnt; ec0 = echo_cnt;
        kq.push_back(8'h16); kq.push_back(8'h3E);
        tick(20);
        check("bp_noecho", echo_cnt - ec0, 0);
        check("bp_onepop", rd_cnt - rd0, 1);
        check("bp_fifo", kq.size(), 1);
        ifc.tx_full = 1'b0;
        @(negedge clk);
        check("bp_release", int'(ifc.echo_wr), 1);
        tick(12);
        check("bp_echoes", echo_cnt - ec0, 2);
        expect_echo("bp_e0", 8'h31);
        expect_echo("bp_e1", 8'h38);
        check("bp_val", int'(entry_val), 18);
        kq.push_back(8'h66);
        tick(8);
        expect_echo("bp_bs", 8'h2D);

        // commit "7" while fib is busy
        ifc.fib_busy = 1'b1;
        st0 = start_cnt;
        kq.push_back(8'h3D); kq.push_back(8'h5A);
        tick(25);
        expect_echo("busy_e0", 8'h37);
        expect_echo("busy_e1", 8'h0D);
        check("busy_nostart", start_cnt - st0, 0);
        check("busy_index", int'(index), 7);
        ifc.fib_busy = 1'b0;
        @(negedge clk);
        check("busy_start_now", int'(ifc.fib_start), 1);
        tick(3);
        check("busy_starts", start_cnt - st0, 1);
        check("busy_val", int'(entry_val), 0);
        ifc.fib_done = 1'b1;
        tick(1);
        ifc.fib_done = 1'b0;
        tick(4);

`ifdef ENTRY_TIMEOUT_EN
        kq.push_back(8'h26);
        tick(8);
        expect_echo("tmo_e0", 8'h33);
        check("tmo_cnt_before", int'(digit_cnt), 1);
        tick(25);
        check("tmo_cnt_after", int'(digit_cnt), 0);
        check("tmo_err", int'(entry_err), 1);
`endif

        // reset while parked in COMMIT
        ifc.fib_busy = 1'b1;
        st0 = start_cnt;
        kq.push_back(8'h16); kq.push_back(8'h5A);
        tick(25);
        expect_echo("rc_e0", 8'h31);
        expect_echo("rc_e1", 8'h0D);
        check("rc_index_pre", int'(index), 1);
        reset = 1'b0;
        #1;
        check("rc_index", int'(index), 0);
        check("rc_val", int'(entry_val), 0);
        check("rc_cnt", int'(digit_cnt), 0);
        check("rc_echo_data", int'(ifc.echo_data), 0);
        check("rc_start", int'(ifc.fib_start), 0);
        tick(3);
        ifc.fib_busy = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(10);
        check("rc_nostart", start_cnt - st0, 0);
        check("rc_index_post", int'(index), 0);

        check("strobe_excl", viol_cnt, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d expected %0d", 1, 0);
        $fatal(1);
    end

endmodule
